// File: rtl/q3_muldiv_pkg.sv
// ============================================================================
// q3_muldiv_pkg : shared cpu types for the Q3 RV32M multiply/divide unit
// Rev 1.0
// ============================================================================
`default_nettype none

package q3_muldiv_pkg;

    localparam int XLEN        = 32;
    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    typedef struct packed {
        logic       valid;
        logic       stall;
        logic       flush;
        logic [4:0] rd;
    } pipe_ctrl_t;

    // Conditional two's-complement negate; doubles as abs() when en = sign bit.
    function automatic logic [31:0] f_cneg32(input logic [31:0] v, input logic en);
        return en ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] f_cneg64(input logic [63:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/q3_muldiv.sv
// ============================================================================
// q3_muldiv : iterative RV32M unit, radix-2 shift-add multiply and restoring
//             divide, 34-cycle latency with early exit for div special cases
// Rev 1.0
// ============================================================================
`default_nettype none

module q3_muldiv
    import q3_muldiv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [4:0]      i_rd_port,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_port
);

    muldiv_state_t r_state;
    muldiv_op_t    r_op;
    logic          r_busy;
    logic          r_valid;
    logic          r_neg;
    logic [5:0]    r_cnt;
    logic [63:0]   r_acc;     // mul: {partial hi, multiplier}; div: low word is quotient/dividend shift
    logic [31:0]   r_rem;
    logic [31:0]   r_opb;     // multiplicand or divisor magnitude
    logic [31:0]   r_result;
    logic [4:0]    r_rd;
    logic [4:0]    r_rd_out;

    muldiv_op_t    w_op;
    logic          w_rs1_signed;
    logic          w_rs2_signed;
    logic [31:0]   w_a;
    logic [31:0]   w_b;
    logic          w_neg;
    logic          w_div0;
    logic          w_ovf;
    logic [31:0]   w_early_res;
    logic [32:0]   w_mul_sum;
    logic [32:0]   w_div_shift;
    logic [32:0]   w_div_trial;
    logic          w_div_ge;
    logic [63:0]   w_prod;
    logic [31:0]   w_quo;
    logic [31:0]   w_remf;
    logic [31:0]   w_final;

    // Operand decode at accept time
    always_comb begin
        w_op         = muldiv_op_t'(i_funct3);
        w_rs1_signed = (w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                       (w_op == OP_DIV)  || (w_op == OP_REM);
        w_rs2_signed = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
        w_a          = f_cneg32(i_rs1_data, w_rs1_signed & i_rs1_data[31]);
        w_b          = f_cneg32(i_rs2_data, w_rs2_signed & i_rs2_data[31]);
        case (w_op)
            OP_MULH, OP_DIV: w_neg = i_rs1_data[31] ^ i_rs2_data[31];
            OP_MULHSU, OP_REM: w_neg = i_rs1_data[31];
            default:         w_neg = 1'b0;
        endcase
        w_div0 = i_funct3[2] && (i_rs2_data == 32'd0);
        w_ovf  = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                 (i_rs1_data == 32'h8000_0000) && (i_rs2_data == 32'hFFFF_FFFF);
        if (w_div0)
            w_early_res = i_funct3[1] ? i_rs1_data : 32'hFFFF_FFFF;
        else
            w_early_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    // One iteration step of each datapath
    always_comb begin
        w_mul_sum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
        w_div_shift = {r_rem, r_acc[31]};
        w_div_trial = w_div_shift - {1'b0, r_opb};
        w_div_ge    = ~w_div_trial[32];
    end

    // Sign fix and result select for the final edge
    always_comb begin
        w_prod  = f_cneg64(r_acc, r_neg);
        w_quo   = f_cneg32(r_acc[31:0], r_neg);
        w_remf  = f_cneg32(r_rem, r_neg);
        case (r_op)
            OP_MUL:                      w_final = w_prod[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[63:32];
            OP_DIV, OP_DIVU:             w_final = w_quo;
            default:                     w_final = w_remf;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_op     <= OP_MUL;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_rd     <= '0;
            r_rd_out <= '0;
        end else if (i_flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_op  <= w_op;
                        r_neg <= w_neg;
                        r_rd  <= i_rd_port;
                        r_cnt <= '0;
                        r_rem <= '0;
                        if (i_funct3[2]) begin
                            r_acc <= {32'd0, w_a};
                            r_opb <= w_b;
                        end else begin
                            r_acc <= {32'd0, w_b};
                            r_opb <= w_a;
                        end
                        r_busy <= 1'b1;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_early_res;
                            r_rd_out <= i_rd_port;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == 6'(MULDIV_ITER)) begin
                        r_result <= w_final;
                        r_rd_out <= r_rd;
                        r_valid  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        if (r_op[2]) begin
                            r_rem <= w_div_ge ? w_div_trial[31:0] : w_div_shift[31:0];
                            r_acc <= {r_acc[63:32], r_acc[30:0], w_div_ge};
                        end else begin
                            r_acc <= {w_mul_sum, r_acc[31:1]};
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_valid   = r_valid;
    assign o_result  = r_result;
    assign o_rd_port = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_q3_muldiv.sv
// ============================================================================
// tb_q3_muldiv : directed and randomized checks of q3_muldiv against an
//                arithmetic reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_q3_muldiv;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [2:0]  i_funct3;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_rd_port;
    logic        i_flush;
    logic        o_busy;
    logic        o_valid;
    logic [31:0] o_result;
    logic [4:0]  o_rd_port;

    int checks = 0;
    int errors = 0;

    q3_muldiv dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_funct3   (i_funct3),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_rd_port  (i_rd_port),
        .i_flush    (i_flush),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result),
        .o_rd_port  (o_rd_port)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 32'd0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        logic [31:0] exp_res;
        int          lat;
        int          k;
        bit          seen;
        exp_res = ref_model(f3, a, b);
        lat     = ref_latency(f3, a, b);
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = f3; i_rs1_data = a; i_rs2_data = b; i_rd_port = rd;
        @(negedge i_clk);
        i_start = 1'b0; i_rs1_data = $urandom; i_rs2_data = $urandom; i_rd_port = 5'd0;
        check({tag, "_busy"}, 64'(o_busy), 64'd1);
        k = 1; seen = 1'b0;
        while (k <= 60 && !seen) begin
            if (o_valid) seen = 1'b1;
            else begin
                @(negedge i_clk);
                k++;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, "_lat"}, 64'(k), 64'(lat));
            check({tag, "_res"}, 64'(o_result), 64'(exp_res));
            check({tag, "_rd"}, 64'(o_rd_port), 64'(rd));
            @(negedge i_clk);
            check({tag, "_pulse"}, 64'(o_valid), 64'd0);
            check({tag, "_idle"}, 64'(o_busy), 64'd0);
            check({tag, "_hold"}, 64'(o_result), 64'(exp_res));
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k;
        int pulses;
        bit any_valid;
        i_rst_n = 1'b0; i_start = 1'b0; i_funct3 = 3'd0;
        i_rs1_data = 32'd0; i_rs2_data = 32'd0; i_rd_port = 5'd0; i_flush = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_result", 64'(o_result), 64'd0);
        check("rst_rd", 64'(o_rd_port), 64'd0);
        i_rst_n = 1'b1;

        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, "mul_7xm3");
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, "mulhu_ff");
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulh_ff");
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhsu_ff");
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, "div_m7_2");
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd8, "rem_m7_2");
        run_op(3'b101, 32'd100, 32'd7, 5'd9, "divu_100_7");
        run_op(3'b111, 32'd100, 32'd7, 5'd10, "remu_100_7");
        run_op(3'b100, 32'd5, 32'd0, 5'd11, "div_5_0");
        run_op(3'b110, 32'd5, 32'd0, 5'd12, "rem_5_0");
        run_op(3'b101, 32'd5, 32'd0, 5'd13, "divu_5_0");
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, "div_ovf");
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, "rem_ovf");

        // flush at RUN cycle 10
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b000; i_rs1_data = 32'd3; i_rs2_data = 32'd5; i_rd_port = 5'd20;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (9) @(negedge i_clk);
        check("flush_prebusy", 64'(o_busy), 64'd1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_busy", 64'(o_busy), 64'd0);
        any_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid) any_valid = 1'b1;
            @(negedge i_clk);
        end
        check("flush_novalid", 64'(any_valid), 64'd0);
        check("flush_rd_held", 64'(o_rd_port), 64'd15);
        run_op(3'b000, 32'd3, 32'd5, 5'd21, "after_flush");

        // flush beats start in the same cycle
        @(negedge i_clk);
        i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'b101; i_rs1_data = 32'd9; i_rs2_data = 32'd0;
        @(negedge i_clk);
        i_start = 1'b0; i_flush = 1'b0;
        check("flush_start_busy", 64'(o_busy), 64'd0);
        check("flush_start_valid", 64'(o_valid), 64'd0);

        // asynchronous reset in the middle of RUN
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b101; i_rs1_data = 32'd1000; i_rs2_data = 32'd3; i_rd_port = 5'd22;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("rstrun_busy", 64'(o_busy), 64'd0);
        check("rstrun_result", 64'(o_result), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (o_valid || o_busy) any_valid = 1'b1;
            @(negedge i_clk);
        end
        check("rstrun_quiet", 64'(any_valid), 64'd0);

        // i_start held high: starts while busy are dropped, back-to-back with no bubble
        @(negedge i_clk);
        i_start = 1'b1; i_funct3 = 3'b101; i_rs1_data = 32'd100; i_rs2_data = 32'd7; i_rd_port = 5'd5;
        @(negedge i_clk);
        i_funct3 = 3'b000; i_rs1_data = 32'd7; i_rs2_data = 32'hFFFF_FFFD; i_rd_port = 5'd6;
        k = 1; pulses = 0;
        while (k <= 100 && pulses < 2) begin
            if (o_valid) begin
                pulses++;
                if (pulses == 1) begin
                    check("held_lat1", 64'(k), 64'd34);
                    check("held_res1", 64'(o_result), 64'd14);
                    check("held_rd1", 64'(o_rd_port), 64'd5);
                end else begin
                    i_start = 1'b0;
                    check("held_lat2", 64'(k), 64'd69);
                    check("held_res2", 64'(o_result), 64'hFFFF_FFEB);
                    check("held_rd2", 64'(o_rd_port), 64'd6);
                end
            end
            if (pulses < 2) begin
                @(negedge i_clk);
                k++;
            end
        end
        i_start = 1'b0;
        check("held_pulses", 64'(pulses), 64'd2);
        @(negedge i_clk);
        check("held_end_valid", 64'(o_valid), 64'd0);

        // randomized ops
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            run_op(f3, a, b, 5'($urandom_range(0, 31)), $sformatf("rnd%0d_f%0d", n, f3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/q3_muldiv.md
Q3_MULDIV -- requirements
Module: q3_muldiv

Interface
REQ-001 SHALL have no parameters; widths are fixed at XLEN 32 and register port 5.
REQ-002 SHALL have port i_clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port i_start, input, 1 bit: an RV32M op from the q2q3 stage is requesting execution.
REQ-005 SHALL have port i_funct3, input, 3 bits: instr[14:12], the op select.
REQ-006 SHALL have port i_rs1_data, input, 32 bits: rs1 operand, which is the multiplicand or dividend.
REQ-007 SHALL have port i_rs2_data, input, 32 bits: rs2 operand, which is the multiplier or divisor.
REQ-008 SHALL have port i_rd_port, input, 5 bits: destination register index.
REQ-009 SHALL have port i_flush, input, 1 bit: abort the in-flight op (branch or exception).
REQ-010 SHALL have port o_busy, output, 1 bit: stall request to the upstream pipeline registers.
REQ-011 SHALL have port o_valid, output, 1 bit: o_result is valid; a one-cycle pulse.
REQ-012 SHALL have port o_result, output, 32 bits: the final result.
REQ-013 SHALL have port o_rd_port, output, 5 bits: destination index for writeback, held from accept.

Function
REQ-014 SHALL decode funct3 as: 000 MUL (low 32 bits); 001 MULH (s×s, high); 010 MULHSU (s×u, high); 011 MULHU (u×u, high); 100 DIV; 101 DIVU; 110 REM; 111 REMU.
REQ-015 SHALL use the states IDLE, RUN and DONE; o_busy = (state != IDLE); o_valid = (state == DONE).
REQ-016 SHALL accept i_start only in IDLE; the accepting edge is E0; i_start in any other state SHALL be ignored.
REQ-017 SHALL capture, at E0: operand magnitudes (absolute value where the op is signed), result sign, op, rd port, and iteration counter = 0; the state then goes to RUN.
REQ-018 SHALL perform multiply as unsigned radix-2 shift-add into a 64-bit accumulator, one bit per cycle.
REQ-019 SHALL perform divide as unsigned restoring division with a 32-bit quotient and 33-bit partial remainder, one bit per cycle.
REQ-020 SHALL spend exactly 32 RUN cycles (edges E1..E32) iterating.
REQ-021 SHALL, at E33, apply the sign fix (two's-complement negate), select the high or low word or the quotient or remainder, register o_result, and enter DONE.
REQ-022 SHALL therefore assert o_valid during the cycle after E33 for one cycle, then return to IDLE.
REQ-023 SHALL, for DIV/DIVU with divisor 0: quotient = 0xFFFFFFFF and remainder = dividend, going directly E0 → DONE (o_valid in the cycle after E0).
REQ-024 SHALL, for DIV with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000 and REM = 0, going directly E0 → DONE.
REQ-025 SHALL take the remainder's sign from the dividend and the quotient's sign as XOR of the operand signs (signed ops only).
REQ-026 SHALL treat MULHSU as rs1 signed and rs2 unsigned; the product sign follows rs1 only.
REQ-027 SHALL, when i_flush is asserted in any state, move to IDLE at the next edge with o_valid not asserted, and no result is produced.
REQ-028 SHALL give i_flush priority over i_start in the same cycle; that start is dropped.
REQ-029 SHALL allow i_start in the cycle directly after DONE (IDLE); back-to-back ops have no extra bubble.
REQ-030 SHALL hold o_result and o_rd_port stable from DONE until the next DONE.

Reset
REQ-031 SHALL, while i_rst_n is low, set: state IDLE, o_busy 0, o_valid 0, o_result 0, o_rd_port 0, counter 0, accumulators 0.
REQ-032 SHALL treat reset during RUN as aborting the op with no o_valid; deassertion resumes in IDLE.

Structure
REQ-033 SHALL take the funct3 op encodings (muldiv_op_t) and the state enum from the shared cpu package, alongside the existing pipeline control typedefs.
REQ-034 SHALL have MULDIV_ITER = 32 as a package constant.
REQ-035 SHALL be a single module; the negate/abs helper is a package function, not a sub-module.

Verification
REQ-036 SHALL cover MUL 7×(−3) (0x00000007, 0xFFFFFFFD): o_valid exactly 34 cycles after the i_start cycle, with o_result 0xFFFFFFEB.
REQ-037 SHALL cover MULHU 0xFFFFFFFF×0xFFFFFFFF giving 0xFFFFFFFE, and MULH on the same operands giving 0x00000000.
REQ-038 SHALL cover DIV −7/2 giving 0xFFFFFFFD, and REM −7/2 giving 0xFFFFFFFF; DIVU 100/7 giving 14, and REMU 100/7 giving 2.
REQ-039 SHALL cover DIV 5/0 giving 0xFFFFFFFF, REM 5/0 giving 5, and DIV 0x80000000/−1 giving 0x80000000; each with o_valid 1 cycle after accept.
REQ-040 SHALL cover i_flush at RUN cycle 10: o_busy low the next cycle, no o_valid pulse, and the next i_start completes correctly.
REQ-041 SHALL cover i_start held high continuously with i_rd_port 5 then 6: two results are produced, o_rd_port 5 then 6, and starts during busy are ignored.
